// File: rtl/lstm_seq_pkg.sv
// Shared types for the LSTM sequence controller.
// Holds the FSM state enum and the default length-counter width.
package lstm_seq_pkg;

  localparam int LEN_WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    FEED  = 3'd2,
    WAIT  = 3'd3,
    DRAIN = 3'd4
  } lstm_seq_state_t;

endpackage

// File: rtl/lstm_sequence_controller.sv
// Streams a whole input sequence through the lstm_layers datapath.
// Optional LSTM_SEQ_KEEP_STATE_EN adds keep_state to skip the state clear.
module lstm_sequence_controller
  import lstm_seq_pkg::*;
#(
  parameter int LAYERS    = 4,
  parameter int WIDTH     = 16,
  parameter int LEN_WIDTH = LEN_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_WIDTH-1:0]    seq_len,
`ifdef LSTM_SEQ_KEEP_STATE_EN
  input  logic                    keep_state,
`endif
  output logic                    busy,
  output logic                    done,
  input  logic [WIDTH-1:0]        x_data,
  input  logic                    x_valid,
  output logic                    x_ready,
  input  logic                    lstm_ready,
  output logic [WIDTH-1:0]        lstm_x_in,
  output logic                    lstm_x_in_valid,
  output logic [LAYERS*WIDTH-1:0] lstm_h_in,
  output logic [LAYERS-1:0]       lstm_h_in_valid,
  output logic [LAYERS*WIDTH-1:0] lstm_C_in,
  output logic [LAYERS-1:0]       lstm_C_in_valid,
  input  logic [WIDTH-1:0]        lstm_y_out,
  input  logic                    lstm_valid,
  output logic [WIDTH-1:0]        y_data,
  output logic                    y_valid,
  input  logic                    y_ready
);

  lstm_seq_state_t      state;
  logic [LEN_WIDTH-1:0] len;
  logic [LEN_WIDTH-1:0] count;
  logic [LAYERS-1:0]    init_oh;
  logic                 keep;
  logic                 x_hs;
  logic                 y_hs;

`ifdef LSTM_SEQ_KEEP_STATE_EN
  assign keep = keep_state;
`else
  assign keep = 1'b0;
`endif

  // Only path from inputs to outputs: new x is held off while a
  // result is still waiting, so y_data can never be overwritten.
  assign x_ready = (state == FEED) && lstm_ready && !y_valid;
  assign x_hs    = x_ready && x_valid;
  assign y_hs    = y_valid && y_ready;

  assign busy            = (state != IDLE);
  assign lstm_h_in       = '0;
  assign lstm_C_in       = '0;
  assign lstm_h_in_valid = init_oh;
  assign lstm_C_in_valid = init_oh;

  // Sequence FSM with the per-layer init strobe and the output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      len             <= '0;
      count           <= '0;
      init_oh         <= '0;
      done            <= 1'b0;
      lstm_x_in       <= '0;
      lstm_x_in_valid <= 1'b0;
      y_data          <= '0;
      y_valid         <= 1'b0;
    end else begin
      done            <= 1'b0;
      lstm_x_in_valid <= 1'b0;
      if (y_hs) y_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (seq_len == '0) begin
              done <= 1'b1;
            end else begin
              len   <= seq_len;
              count <= '0;
              if (keep) begin
                state <= FEED;
              end else begin
                state   <= INIT;
                init_oh <= LAYERS'(1);
              end
            end
          end
        end
        INIT: begin
          init_oh <= init_oh << 1;
          if (init_oh[LAYERS-1]) state <= FEED;
        end
        FEED: begin
          if (x_hs) begin
            lstm_x_in       <= x_data;
            lstm_x_in_valid <= 1'b1;
            count           <= count + 1'b1;
            state           <= WAIT;
          end
        end
        WAIT: begin
          if (lstm_valid) begin
            y_data  <= lstm_y_out;
            y_valid <= 1'b1;
            state   <= (count == len) ? DRAIN : FEED;
          end
        end
        DRAIN: begin
          if (y_hs) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lstm_sequence_controller.sv
// Self-checking bench for lstm_sequence_controller.
// Datapath model returns y = x + 1 after a configurable latency.
`timescale 1ns/1ps
module tb_lstm_sequence_controller;

  localparam int LAYERS    = 4;
  localparam int WIDTH     = 16;
  localparam int LEN_WIDTH = 16;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic [LEN_WIDTH-1:0]    seq_len;
`ifdef LSTM_SEQ_KEEP_STATE_EN
  logic                    keep_state;
`endif
  logic                    busy;
  logic                    done;
  logic [WIDTH-1:0]        x_data;
  logic                    x_valid;
  logic                    x_ready;
  logic                    lstm_ready;
  logic [WIDTH-1:0]        lstm_x_in;
  logic                    lstm_x_in_valid;
  logic [LAYERS*WIDTH-1:0] lstm_h_in;
  logic [LAYERS-1:0]       lstm_h_in_valid;
  logic [LAYERS*WIDTH-1:0] lstm_C_in;
  logic [LAYERS-1:0]       lstm_C_in_valid;
  logic [WIDTH-1:0]        lstm_y_out;
  logic                    lstm_valid;
  logic [WIDTH-1:0]        y_data;
  logic                    y_valid;
  logic                    y_ready;

  lstm_sequence_controller #(
    .LAYERS(LAYERS), .WIDTH(WIDTH), .LEN_WIDTH(LEN_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .seq_len(seq_len),
`ifdef LSTM_SEQ_KEEP_STATE_EN
    .keep_state(keep_state),
`endif
    .busy(busy), .done(done),
    .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
    .lstm_ready(lstm_ready), .lstm_x_in(lstm_x_in),
    .lstm_x_in_valid(lstm_x_in_valid),
    .lstm_h_in(lstm_h_in), .lstm_h_in_valid(lstm_h_in_valid),
    .lstm_C_in(lstm_C_in), .lstm_C_in_valid(lstm_C_in_valid),
    .lstm_y_out(lstm_y_out), .lstm_valid(lstm_valid),
    .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 5;

  int               pend_t[$];
  logic [WIDTH-1:0] pend_v[$];
  logic [WIDTH-1:0] src_q[$];
  logic [WIDTH-1:0] obs_q[$];
  logic [LAYERS-1:0] sh[16];
  logic [LAYERS-1:0] sc[16];

  int xin_cnt, done_cnt, done_busy, busy_gap, stall_bad;
  int xr_bad, zero_bad, first_xr, timeout, extra_done;

  // One clock; then the datapath model reacts to what the DUT issued.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (lstm_x_in_valid) begin
      xin_cnt++;
      pend_t.push_back(cyc + lat);
      pend_v.push_back(lstm_x_in + 16'd1);
    end
    lstm_valid = 1'b0;
    lstm_y_out = WIDTH'($urandom);
    if (pend_t.size() > 0 && pend_t[0] <= cyc) begin
      lstm_valid = 1'b1;
      lstm_y_out = pend_v.pop_front();
      void'(pend_t.pop_front());
    end
    if (lstm_h_in !== '0 || lstm_C_in !== '0) zero_bad++;
  endtask

  // Drives one whole sequence from src_q and records what comes out.
  task automatic run_seq(input int ypct, input int lpct,
                         input bit stall10, input bit restart);
    int idx = 0;
    int rel = 0;
    int stall_left = 0;
    bit stalled = 0;
    bit held_v = 0;
    logic [WIDTH-1:0] held_d = '0;
    obs_q.delete();
    xin_cnt = 0; done_cnt = 0; done_busy = 1; busy_gap = 0;
    stall_bad = 0; xr_bad = 0; zero_bad = 0; first_xr = -1;
    timeout = 0; extra_done = 0;
    for (int i = 0; i < 16; i++) begin
      sh[i] = '0;
      sc[i] = '0;
    end
    start   = 1'b1;
    seq_len = LEN_WIDTH'(src_q.size());
    while (done_cnt == 0) begin
      tick();
      rel++;
      start = restart;
      if (restart) seq_len = LEN_WIDTH'($urandom_range(1, 9));
      if (rel < 16) begin
        sh[rel] = lstm_h_in_valid;
        sc[rel] = lstm_C_in_valid;
      end
      if (done) begin
        done_cnt++;
        done_busy = busy;
        start = 1'b0;
      end else if (!busy) begin
        busy_gap++;
      end
      if (held_v && y_data !== held_d) stall_bad++;
      y_ready = ($urandom_range(0, 99) >= ypct);
      if (stall10 && y_valid && !stalled) begin
        stalled = 1;
        stall_left = 10;
      end
      if (stall_left > 0) begin
        y_ready = 1'b0;
        stall_left--;
      end
      lstm_ready = ($urandom_range(0, 99) >= lpct);
      x_valid = (idx < src_q.size()) && ($urandom_range(0, 99) >= lpct);
      x_data  = x_valid ? src_q[idx] : WIDTH'($urandom);
      #1;
      if (x_ready && y_valid) xr_bad++;
      if (x_ready && first_xr < 0) first_xr = rel;
      if (x_ready && x_valid) idx++;
      held_v = y_valid && !y_ready;
      held_d = y_data;
      if (y_valid && y_ready) obs_q.push_back(y_data);
      if (rel > 3000) begin
        timeout = 1;
        break;
      end
    end
    start = 1'b0;
    x_valid = 1'b0;
    y_ready = 1'b1;
    repeat (4) begin
      tick();
      if (done) extra_done++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; seq_len = '0; x_data = '0;
    x_valid = 1'b0; lstm_ready = 1'b0; y_ready = 1'b0;
    lstm_valid = 1'b0; lstm_y_out = '0;
    repeat (3) tick();
    checks++;
    if ({busy, done, lstm_x_in_valid, y_valid, lstm_h_in_valid,
         lstm_C_in_valid} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0", {busy, done,
               lstm_x_in_valid, y_valid, lstm_h_in_valid,
               lstm_C_in_valid});
    end
    checks++;
    if ({lstm_x_in, y_data, lstm_h_in, lstm_C_in} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h %h want 0", lstm_x_in, y_data);
    end
    lstm_ready = 1'b1;
    #1;
    checks++;
    if (x_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_x_ready: got %b want 0", x_ready);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_init_three();
    logic [LAYERS-1:0] e;
    src_q = '{16'h0100, 16'h0200, 16'h0300};
    lat = 5;
    run_seq(0, 0, 0, 0);
    checks++;
    if (timeout != 0) begin
      errors++;
      $display("FAIL three_timeout: got %0d want 0", timeout);
    end
    for (int r = 1; r <= 5; r++) begin
      e = (r <= LAYERS) ? (LAYERS'(1) << (r - 1)) : '0;
      checks++;
      if (sh[r] !== e || sc[r] !== e) begin
        errors++;
        $display("FAIL init_strobe c%0d: got h=%b C=%b want %b",
                 r, sh[r], sc[r], e);
      end
    end
    checks++;
    if (first_xr != LAYERS + 1) begin
      errors++;
      $display("FAIL first_x_ready: got %0d want %0d", first_xr, LAYERS + 1);
    end
    checks++;
    if (obs_q.size() != 3) begin
      errors++;
      $display("FAIL three_count: got %0d want 3", obs_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_q[i] !== src_q[i] + 16'd1) begin
          errors++;
          $display("FAIL three_y%0d: got %h want %h", i, obs_q[i],
                   src_q[i] + 16'd1);
        end
      end
    end
    checks++;
    if (done_cnt != 1 || extra_done != 0 || done_busy != 0) begin
      errors++;
      $display("FAIL three_done: got cnt=%0d extra=%0d busy=%0d want 1 0 0",
               done_cnt, extra_done, done_busy);
    end
    checks++;
    if (busy_gap != 0 || xin_cnt != 3 || zero_bad != 0) begin
      errors++;
      $display("FAIL three_misc: got gap=%0d xin=%0d zero=%0d want 0 3 0",
               busy_gap, xin_cnt, zero_bad);
    end
  endtask

  task automatic test_backpressure();
    src_q.delete();
    repeat (3) src_q.push_back(WIDTH'($urandom));
    lat = 3;
    run_seq(0, 0, 1, 0);
    checks++;
    if (timeout != 0 || stall_bad != 0 || xr_bad != 0) begin
      errors++;
      $display("FAIL bp_hold: got to=%0d stall=%0d xr=%0d want 0 0 0",
               timeout, stall_bad, xr_bad);
    end
    checks++;
    if (obs_q.size() != 3) begin
      errors++;
      $display("FAIL bp_count: got %0d want 3", obs_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_q[i] !== src_q[i] + 16'd1) begin
          errors++;
          $display("FAIL bp_y%0d: got %h want %h", i, obs_q[i],
                   src_q[i] + 16'd1);
        end
      end
    end
  endtask

  task automatic test_zero_len();
    start = 1'b1;
    seq_len = '0;
    tick();
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || lstm_h_in_valid !== '0) begin
      errors++;
      $display("FAIL zero_len_c1: got done=%b busy=%b h=%b want 1 0 0",
               done, busy, lstm_h_in_valid);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || lstm_h_in_valid !== '0) begin
      errors++;
      $display("FAIL zero_len_c2: got done=%b busy=%b h=%b want 0 0 0",
               done, busy, lstm_h_in_valid);
    end
  endtask

  task automatic test_ignored_start();
    src_q.delete();
    repeat (3) src_q.push_back(WIDTH'($urandom));
    lat = 2;
    run_seq(20, 20, 0, 1);
    checks++;
    if (timeout != 0 || done_cnt != 1 || extra_done != 0) begin
      errors++;
      $display("FAIL busy_start_done: got to=%0d cnt=%0d extra=%0d want 0 1 0",
               timeout, done_cnt, extra_done);
    end
    checks++;
    if (obs_q.size() != 3) begin
      errors++;
      $display("FAIL busy_start_count: got %0d want 3", obs_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_q[i] !== src_q[i] + 16'd1) begin
          errors++;
          $display("FAIL busy_start_y%0d: got %h want %h", i, obs_q[i],
                   src_q[i] + 16'd1);
        end
      end
    end
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 8);
      src_q.delete();
      repeat (n) src_q.push_back(WIDTH'($urandom));
      lat = $urandom_range(1, 7);
      run_seq($urandom_range(0, 60), $urandom_range(0, 60), 0, 0);
      checks++;
      if (timeout != 0 || stall_bad != 0 || xr_bad != 0 || busy_gap != 0) begin
        errors++;
        $display("FAIL rand%0d_proto: got to=%0d st=%0d xr=%0d gap=%0d want 0",
                 it, timeout, stall_bad, xr_bad, busy_gap);
      end
      checks++;
      if (done_cnt != 1 || extra_done != 0 || done_busy != 0 || xin_cnt != n) begin
        errors++;
        $display("FAIL rand%0d_done: got cnt=%0d ex=%0d b=%0d xin=%0d want 1 0 0 %0d",
                 it, done_cnt, extra_done, done_busy, xin_cnt, n);
      end
      checks++;
      if (obs_q.size() != n) begin
        errors++;
        $display("FAIL rand%0d_count: got %0d want %0d", it, obs_q.size(), n);
      end else begin
        for (int i = 0; i < n; i++) begin
          checks++;
          if (obs_q[i] !== src_q[i] + 16'd1) begin
            errors++;
            $display("FAIL rand%0d_y%0d: got %h want %h", it, i, obs_q[i],
                     src_q[i] + 16'd1);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    int saw = 0;
    int bad_done = 0;
    int bad_y = 0;
    int bad_busy = 0;
    lat = 6;
    start = 1'b1;
    seq_len = LEN_WIDTH'(3);
    lstm_ready = 1'b1;
    x_valid = 1'b1;
    x_data = WIDTH'($urandom);
    y_ready = 1'b0;
    for (int i = 0; i < 50 && saw == 0; i++) begin
      tick();
      start = 1'b0;
      if (lstm_x_in_valid) saw = 1;
    end
    checks++;
    if (saw != 1) begin
      errors++;
      $display("FAIL midwait_reach: got %0d want 1", saw);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (12) begin
      tick();
      if (done) bad_done++;
      if (y_valid) bad_y++;
      if (busy) bad_busy++;
    end
    checks++;
    if (bad_done != 0 || bad_y != 0 || bad_busy != 0) begin
      errors++;
      $display("FAIL midwait_abort: got done=%0d yv=%0d busy=%0d want 0 0 0",
               bad_done, bad_y, bad_busy);
    end
    x_valid = 1'b0;
    y_ready = 1'b1;
    pend_t.delete();
    pend_v.delete();
  endtask

`ifdef LSTM_SEQ_KEEP_STATE_EN
  task automatic test_keep_state();
    int strobes = 0;
    src_q.delete();
    repeat (2) src_q.push_back(WIDTH'($urandom));
    lat = 4;
    keep_state = 1'b1;
    run_seq(0, 0, 0, 0);
    keep_state = 1'b0;
    for (int r = 1; r < 16; r++) if (sh[r] != 0 || sc[r] != 0) strobes++;
    checks++;
    if (strobes != 0 || first_xr != 1) begin
      errors++;
      $display("FAIL keep_state: got strobes=%0d first_xr=%0d want 0 1",
               strobes, first_xr);
    end
    checks++;
    if (obs_q.size() != 2 || obs_q[0] !== src_q[0] + 16'd1 ||
        obs_q[1] !== src_q[1] + 16'd1) begin
      errors++;
      $display("FAIL keep_state_y: got %0d results want 2 matching",
               obs_q.size());
    end
  endtask
`endif

  initial begin
`ifdef LSTM_SEQ_KEEP_STATE_EN
    keep_state = 1'b0;
`endif
    test_reset();
    test_init_three();
    test_backpressure();
    test_zero_len();
    test_ignored_start();
    test_random();
    test_reset_mid_wait();
`ifdef LSTM_SEQ_KEEP_STATE_EN
    test_keep_state();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lstm_sequence_controller.md
# lstm_sequence_controller

Sequences a complete input sequence through the `lstm_layers` datapath without per-sample software writes. On `start` it clears the per-layer hidden and cell state, or optionally keeps it. It then streams `seq_len` x samples into the datapath one at a time, honouring the datapath's `ready`. Each `y_out` is returned on a valid/ready output stream. It sits between a sample source (DMA or FIFO) and `lstm_layers`, beside the AXI4-Lite register path.

## Interface
- `LAYERS`, 4, number of LSTM layers driven
- `WIDTH`, 16, sample / state width (signed fixed point)
- `LEN_WIDTH`, 16, width of `seq_len`
- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-high
- `start` in 1: begin a sequence; sampled only in IDLE
- `seq_len` in LEN_WIDTH: number of samples, sampled with `start`
- `busy` out 1: high from the cycle after accepted `start` until the `done` cycle
- `done` out 1: one-cycle pulse when the sequence completes
- `x_data` in WIDTH: input sample
- `x_valid` in 1: input sample valid
- `x_ready` out 1: input sample accepted when `x_valid` is also high
- `lstm_ready` in 1: datapath `ready`
- `lstm_x_in` out WIDTH: datapath x input
- `lstm_x_in_valid` out 1: datapath x input strobe
- `lstm_h_in` out LAYERS*WIDTH: datapath initial hidden state, all zero
- `lstm_h_in_valid` out LAYERS: datapath per-layer hidden-state strobes
- `lstm_C_in` out LAYERS*WIDTH: datapath initial cell state, all zero
- `lstm_C_in_valid` out LAYERS: datapath per-layer cell-state strobes
- `lstm_y_out` in WIDTH: datapath result
- `lstm_valid` in 1: datapath result strobe
- `y_data` out WIDTH: output sample
- `y_valid` out 1: output sample valid
- `y_ready` in 1: output sample accepted when `y_valid` is also high

## Operation
States are IDLE, INIT, FEED, WAIT and DRAIN.
- **IDLE**
  - `start` with `seq_len==0`: no INIT; `done` pulses next cycle; stay IDLE.
  - `start` with `seq_len>0`: latch length, clear count, go to INIT.
- **INIT** runs LAYERS cycles, with layer index i = 0..LAYERS-1.
  - Cycle i: `lstm_h_in_valid` and `lstm_C_in_valid` are one-hot at bit i; data is zero.
  - After the last layer, go to FEED.
- **FEED**
  - `x_ready = lstm_ready && !y_valid`.
  - On handshake: register `x_data` into `lstm_x_in`; pulse `lstm_x_in_valid` next cycle; increment count; go to WAIT.
- **WAIT**
  - On `lstm_valid`: register `lstm_y_out` into `y_data` and set `y_valid` next cycle.
  - If count==seq_len, go to DRAIN; else go to FEED.
  - `lstm_valid` outside WAIT is ignored.
- **DRAIN**: on the `y_valid && y_ready` handshake, pulse `done` the next cycle, drop `busy` the same cycle, and go to IDLE.
- `y_valid` holds with `y_data` stable until `y_ready`; a new x is never issued while `y_valid` is high, so results are never overwritten.
- `start` while busy is ignored.
- Count arithmetic is unsigned LEN_WIDTH. Maximum length is 2^LEN_WIDTH−1; no wrap occurs.

## Timing
- Reset values:
  - all outputs 0;
  - `lstm_h_in` and `lstm_C_in` are always 0;
  - state IDLE, count 0.
- `rst` mid-sequence aborts immediately: no `done` pulse, `y_valid` dropped, any pending `lstm_valid` ignored.
- `start` at cycle 0 gives `busy=1` and INIT strobe bit 0 at cycle 1, through bit LAYERS−1 at cycle LAYERS. `x_ready` can first be high at cycle LAYERS+1.
- An x handshake at cycle t puts `lstm_x_in_valid` high at cycle t+1 only.
- `lstm_valid` at cycle t puts `y_valid` high at t+1.
- Throughput is one sample per datapath latency + 2 cycles, plus any `y_ready` stall.
- `x_ready` is combinational from `lstm_ready`, `y_valid` and the state. No other output has a combinational path from inputs.

## Configuration
- `LSTM_SEQ_KEEP_STATE_EN` defined:
  - adds input `keep_state` (1 bit), sampled with `start`;
  - when high, INIT is skipped (IDLE goes directly to FEED) and layer state carries over from the previous sequence.
- `LSTM_SEQ_KEEP_STATE_EN` undefined: the port is absent and INIT always runs.

## Structure
- Shared package `lstm_seq_pkg` holds:
  - the state enum typedef `lstm_seq_state_t` {IDLE, INIT, FEED, WAIT, DRAIN};
  - the default `LEN_WIDTH` localparam.
- Single flat module; no sub-module is warranted. The INIT strobe is a shifted one-hot register inside the FSM.

## Test plan
- **Reset:** assert `rst` 3 cycles → all outputs 0, `busy=0`, `x_ready=0`.
- **INIT sequencing:** `start`, `seq_len=3`, LAYERS=4 → cycles 1–4 show h/C valid 0001, 0010, 0100, 1000 with zero data.
- **Three-sample run:** feed x = 0x0100, 0x0200, 0x0300 with a model datapath returning y = x+1 after 5 cycles, `y_ready` tied high → `y_data` 0x0101, 0x0201, 0x0301 in order; `done` pulses once; `busy` falls the same cycle.
- **Output backpressure:** hold `y_ready` low 10 cycles after the first y → `x_ready` stays 0 and `y_data` is stable; releasing it resumes the sequence.
- **`seq_len=0` and ignored `start`:** `start` with `seq_len=0` → `done` next cycle, no INIT strobes. `start` while busy → no effect.
- **Reset mid-WAIT, then keep-state:**
  - `rst` mid-WAIT → IDLE, no `done`.
  - With `LSTM_SEQ_KEEP_STATE_EN` and `keep_state=1` → no INIT strobes; `x_ready` is high at cycle 1.
